// File: rtl/pipe_sequencer_if.sv
// Control bundle between the pipeline datapath and pipe_sequencer.
// Counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_sequencer_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic [31:0] inst_d;
   logic [31:0] inst_x;
   logic        br_taken_x;
   logic        dmem_req_m;
   logic        dmem_ack_m;
   logic        halt_req;
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        memwb_flush;
   logic        halted;
   logic        timeout_err;
`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] ldstall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] memwait_cnt;

   modport master (
      input  inst_d, inst_x, br_taken_x, dmem_req_m, dmem_ack_m, halt_req,
      output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
      output halted, timeout_err, ldstall_cnt, flush_cnt, memwait_cnt
   );
   modport slave (
      output inst_d, inst_x, br_taken_x, dmem_req_m, dmem_ack_m, halt_req,
      input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
      input  halted, timeout_err, ldstall_cnt, flush_cnt, memwait_cnt
   );
`else
   modport master (
      input  inst_d, inst_x, br_taken_x, dmem_req_m, dmem_ack_m, halt_req,
      output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
      output halted, timeout_err
   );
   modport slave (
      output inst_d, inst_x, br_taken_x, dmem_req_m, dmem_ack_m, halt_req,
      input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
      input  halted, timeout_err
   );
`endif
endinterface

// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, mem freeze, halt drain.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_sequencer #(
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input logic              clk,
   input logic              rst_n,
   pipe_sequencer_if.master bus
);
   localparam int unsigned WaitW  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

   state_e             state_q;
   logic [WaitW-1:0]   wait_cnt_q;
   logic [DrainW-1:0]  drain_cnt_q;
   logic               timeout_q;

   logic [6:0] opc_x, opc_d;
   logic [4:0] rd_x;
   logic       rs1_used, rs2_used, load_use, mem_stall, wait_expired;

   always_comb begin
      opc_x     = bus.inst_x[6:0];
      opc_d     = bus.inst_d[6:0];
      rd_x      = bus.inst_x[11:7];
      rs1_used  = !(opc_d inside {7'b0110111, 7'b0010111, 7'b1101111});
      rs2_used  = opc_d inside {7'b0110011, 7'b0100011, 7'b1100011};
      load_use  = (opc_x == 7'b0000011) && (rd_x != 5'd0) &&
                  ((rs1_used && (rd_x == bus.inst_d[19:15])) ||
                   (rs2_used && (rd_x == bus.inst_d[24:20])));
      mem_stall    = bus.dmem_req_m && !bus.dmem_ack_m;
      wait_expired = (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));
   end

   logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
               memwb_flush = 1'b1;
            end else if (bus.br_taken_x) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (bus.halt_req) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         StMemWait: begin
            if (!bus.dmem_ack_m) begin
               {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
               memwb_flush = 1'b1;
            end
         end
         StDrain: begin
            if (mem_stall) begin
               {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
               memwb_flush = 1'b1;
            end else begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         StHalted: begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            {ifid_flush, idex_flush, memwb_flush} = 3'b111;
         end
         default: ;
      endcase
   end

   // Reset acts combinationally on the controls, ahead of the registered state.
   assign bus.pc_en       = rst_n & pc_en;
   assign bus.ifid_en     = rst_n & ifid_en;
   assign bus.idex_en     = rst_n & idex_en;
   assign bus.exmem_en    = rst_n & exmem_en;
   assign bus.ifid_flush  = ~rst_n | ifid_flush;
   assign bus.idex_flush  = ~rst_n | idex_flush;
   assign bus.memwb_flush = ~rst_n | memwb_flush;
   assign bus.halted      = (state_q == StHalted);
   assign bus.timeout_err = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_stall) begin
                  state_q    <= StMemWait;
                  wait_cnt_q <= '0;
               end else if (!bus.br_taken_x && !load_use && bus.halt_req) begin
                  state_q     <= StDrain;
                  drain_cnt_q <= DrainW'(DRAIN_CYCLES);
                  wait_cnt_q  <= '0;
               end
            end
            StMemWait: begin
               if (bus.dmem_ack_m) begin
                  state_q <= StRun;
               end else if (wait_expired) begin
                  timeout_q <= 1'b1;
                  state_q   <= StHalted;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
            end
            StDrain: begin
               if (mem_stall) begin
                  if (wait_expired) begin
                     timeout_q <= 1'b1;
                     state_q   <= StHalted;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + WaitW'(1);
                  end
               end else begin
                  wait_cnt_q  <= '0;
                  drain_cnt_q <= drain_cnt_q - DrainW'(1);
                  if (drain_cnt_q == DrainW'(1)) state_q <= StHalted;
               end
            end
            StHalted: ;
            default: state_q <= StHalted;
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] ldstall_q, flush_q, memwait_q;
   logic             ldstall_inc, flush_inc, memwait_inc;

   always_comb begin
      ldstall_inc = (state_q == StRun) && !mem_stall && !bus.br_taken_x && load_use;
      flush_inc   = (state_q == StRun) && !mem_stall && bus.br_taken_x;
      memwait_inc = ((state_q == StRun) && mem_stall) ||
                    ((state_q == StMemWait) && !bus.dmem_ack_m) ||
                    ((state_q == StDrain) && mem_stall);
   end

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ldstall_q <= '0;
         flush_q   <= '0;
         memwait_q <= '0;
      end else begin
         if (ldstall_inc && !(&ldstall_q)) ldstall_q <= ldstall_q + CNT_W'(1);
         if (flush_inc && !(&flush_q))     flush_q   <= flush_q + CNT_W'(1);
         if (memwait_inc && !(&memwait_q)) memwait_q <= memwait_q + CNT_W'(1);
      end
   end

   assign bus.ldstall_cnt = ldstall_q;
   assign bus.flush_cnt   = flush_q;
   assign bus.memwait_cnt = memwait_q;
`endif
endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central stall/flush sequencer for the 5-stage RISC-V pipeline, sitting beside the forwarding unit. Detects load-use interlocks and taken-branch flushes, freezes the whole pipeline while the MEM-stage data memory handshake is pending, and drains and halts the core on a halt request. Drives the enable/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MEM_TIMEOUT, 16: consecutive MEM_WAIT cycles before a timeout error (≥2)
- DRAIN_CYCLES, 3: cycles spent draining ID..WB after halt accept (≥1)
- CNT_W, 32: width of performance counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- inst_d  in  32  instruction in ID
- inst_x  in  32  instruction in EX
- br_taken_x  in  1  branch/jump in EX resolved taken
- dmem_req_m  in  1  MEM stage issues a data memory access
- dmem_ack_m  in  1  data memory completes the access this cycle
- halt_req  in  1  ID holds a halting instruction (ecall/ebreak)
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register advance enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a NOP bubble
- halted  out  1  core stopped
- timeout_err  out  1  sticky memory timeout flag
- ldstall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  perf counters (macro only)

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are Mealy (state + inputs); state, counters and flags are registered.
- Default (RUN, no event): all enables 1, all flushes 0.
- RUN priority, highest first:
  - Mem stall (dmem_req_m & !dmem_ack_m): all four enables 0, memwb_flush=1; next MEM_WAIT, wait counter cleared.
  - Branch (br_taken_x): pc_en=1, ifid_flush=1, idex_flush=1; overrides load-use and halt_req.
  - Load-use: inst_x[6:0]=0000011, rd=inst_x[11:7]≠0, and rd==inst_d[19:15] (rs1 used unless inst_d opcode is 0110111/0010111/1101111) or rd==inst_d[24:20] (rs2 used only for opcodes 0110011/0100011/1100011). Response: pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en=1. One cycle only.
  - Halt (halt_req): pc_en=0, ifid_flush=1; drain counter loaded with DRAIN_CYCLES; next DRAIN.
- MEM_WAIT: freeze as above every cycle; branch, load-use and halt inputs ignored. Cycle with dmem_ack_m=1: RUN default outputs, next RUN. Wait counter reaching MEM_TIMEOUT-1 without ack: timeout_err←1, next HALTED.
- DRAIN: pc_en=0, ifid_flush=1, others advance; br_taken_x ignored. Mem stall freezes as in MEM_WAIT while holding the drain counter (state stays DRAIN; timeout rule applies). Counter decrements per advancing cycle; at 1→0 next HALTED.
- HALTED: all enables 0, all flushes 1, halted=1; exit only via reset.
- rst_n low: state RUN, all counters 0, halted=0, timeout_err=0; enables forced 0, flushes forced 1 until rst_n deasserts.
- Simultaneous req&ack in RUN: no stall.

## Timing
- Stall/flush responses are combinational in the detecting cycle (0-cycle latency); state updates on the next rising edge.
- Load-use inserts exactly 1 bubble; taken branch costs 2 squashed slots.
- Halt: halted asserts DRAIN_CYCLES cycles after the halt_req acceptance edge, plus frozen mem-wait cycles.
- Reset assertion acts immediately; first RUN cycle is the first edge after rst_n rises.

## Configuration
- PIPE_PERF_CNT_EN defined: ldstall_cnt (+1 per load-use bubble), flush_cnt (+1 per accepted taken branch), memwait_cnt (+1 per frozen cycle) present; saturate at all-ones; cleared by reset.
- Undefined: counter ports and logic absent; all other behaviour identical.

## Test plan
- inst_x=lw x5,0(x1) (0x0000A283), inst_d=add x6,x5,x2 (0x00228333) -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle defaults; ldstall_cnt=1.
- Same load, inst_d=lui x5 (0x000052B7) or rd=x0 load -> no stall.
- br_taken_x=1 with concurrent load-use -> ifid_flush=idex_flush=1, pc_en=1; ldstall_cnt unchanged, flush_cnt=1.
- dmem_req_m=1, ack after 4 cycles -> 4 frozen cycles (memwb_flush=1), then advance; memwait_cnt=4; with no ack for MEM_TIMEOUT=16 cycles -> timeout_err=1, halted=1.
- halt_req in RUN, one 2-cycle mem stall during drain -> halted asserts 3+2 cycles later, pc_en=0 throughout.
- rst_n pulsed low mid-MEM_WAIT -> enables 0/flushes 1 immediately; after release state RUN, counters 0, timeout_err=0.
